// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory controller slice.
// Optional parity storage is enabled by defining MEM_PARITY_EN.
package mem_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int LATENCY_DEF = 2;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/ram_array.sv
// Word-addressed RAM: synchronous write, combinational read, no reset.
// With MEM_PARITY_EN each word carries an extra even-parity bit in its MSB.
module ram_array #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
`ifdef MEM_PARITY_EN
    input  logic [DATA_W:0]   i_wword,
    output logic [DATA_W:0]   o_rword
`else
    input  logic [DATA_W-1:0] i_wword,
    output logic [DATA_W-1:0] o_rword
`endif
);
`ifdef MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clock) begin
        if (i_we) r_mem[i_addr] <= i_wword;
    end

    assign o_rword = r_mem[i_addr];
endmodule

// File: rtl/mem_ctrl.sv
// Multi-cycle memory controller feeding the MDR: IDLE -> WAIT -> DONE handshake.
// Define MEM_PARITY_EN to store per-word parity and report read mismatches.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              parity_err
);
    localparam logic [CNT_W-1:0] LAT_M1 = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_rd;
    logic [DATA_W-1:0] r_rdata;
    logic              r_busy;
    logic              r_done;
    logic              w_we;

    // Writes commit only in DONE, so a clear during WAIT leaves memory untouched.
    assign w_we = (r_state == ST_DONE) && !r_is_rd;

`ifdef MEM_PARITY_EN
    logic [DATA_W:0] w_wword, w_rword;
    logic            r_parity_err;
    assign w_wword = {^r_wdata, r_wdata};
`else
    logic [DATA_W-1:0] w_wword, w_rword;
    assign w_wword = r_wdata;
`endif

    ram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .i_clock (clock),
        .i_we    (w_we),
        .i_addr  (r_addr),
        .i_wword (w_wword),
        .o_rword (w_rword)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_is_rd <= 1'b0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (read || write) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_is_rd <= read;
                        r_busy  <= 1'b1;
                        r_cnt   <= LAT_M1;
                        r_state <= (LATENCY > 0) ? ST_WAIT : ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) r_state <= ST_DONE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                ST_DONE: begin
                    if (r_is_rd) r_rdata <= w_rword[DATA_W-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_PARITY_EN
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            r_parity_err <= 1'b0;
        else if (r_state == ST_DONE && r_is_rd)
            r_parity_err <= w_rword[DATA_W] != ^w_rword[DATA_W-1:0];
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign rdata = r_rdata;
    assign busy  = r_busy;
    assign done  = r_done;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl at the default LATENCY=2.
// The parity corruption step is built only when MEM_PARITY_EN is defined.
module tb_mem_ctrl;
    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        read  = 1'b0;
    logic        write = 1'b0;
    logic [8:0]  addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy, done, parity_err;

    int total = 0;
    int bad   = 0;

    mem_ctrl dut (
        .clock      (clock),
        .clear      (clear),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access with exact handshake timing: accept at edge N, done after N+3.
    task automatic op(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d,
                      input string tag);
        @(negedge clock);
        read = rd; write = wr; addr = a; wdata = d;
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0; addr = 9'($urandom); wdata = $urandom;
        chk({tag, ".busy_acc"}, 32'(busy), 32'd1);
        chk({tag, ".done_acc"}, 32'(done), 32'd0);
        for (int i = 1; i <= 2; i++) begin
            @(posedge clock); #1;
            chk({tag, ".busy_wait"}, 32'(busy), 32'd1);
            chk({tag, ".done_wait"}, 32'(done), 32'd0);
        end
        @(posedge clock); #1;
        chk({tag, ".done_pulse"}, 32'(done), 32'd1);
        chk({tag, ".busy_end"},   32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.perr", 32'(parity_err), 32'd0);
        @(negedge clock); clear = 1'b0;
        @(posedge clock); #1;
        chk("rel.busy", 32'(busy), 32'd0);
        chk("rel.done", 32'(done), 32'd0);

        // Seed known contents for later checks
        op(1'b0, 1'b1, 9'h007, 32'h07070707, "seed7");
        op(1'b0, 1'b1, 9'h010, 32'h10101010, "seed10");
        op(1'b0, 1'b1, 9'h020, 32'h20202020, "seed20");
        chk("seed.rdata_unchanged", rdata, 32'h0);

        op(1'b0, 1'b1, 9'h005, 32'hAAAAAAAA, "wr5");
        op(1'b1, 1'b0, 9'h005, 32'h0, "rd5");
        chk("rd5.rdata", rdata, 32'hAAAAAAAA);
        chk("rd5.perr", 32'(parity_err), 32'd0);

        op(1'b0, 1'b1, 9'h006, 32'hFFFFFFFF, "wr6");
        chk("wr6.rdata_hold", rdata, 32'hAAAAAAAA);
        op(1'b1, 1'b0, 9'h005, 32'h0, "rd5b");
        chk("rd5b.rdata", rdata, 32'hAAAAAAAA);
        op(1'b1, 1'b0, 9'h006, 32'h0, "rd6");
        chk("rd6.rdata", rdata, 32'hFFFFFFFF);

        // Read and write together: read wins, write dropped
        op(1'b1, 1'b1, 9'h010, 32'h12345678, "rw10");
        chk("rw10.rdata", rdata, 32'h10101010);
        op(1'b1, 1'b0, 9'h010, 32'h0, "rd10");
        chk("rd10.rdata", rdata, 32'h10101010);

        // Write strobe while busy on a read is ignored
        @(negedge clock);
        read = 1'b1; addr = 9'h005;
        @(posedge clock); #1;
        read = 1'b0;
        @(negedge clock);
        write = 1'b1; addr = 9'h007; wdata = 32'hDEADBEEF;
        @(posedge clock); #1;
        write = 1'b0;
        chk("intr.busy", 32'(busy), 32'd1);
        @(negedge clock);
        write = 1'b1;
        @(posedge clock); #1;
        write = 1'b0;
        @(posedge clock); #1;
        chk("intr.done", 32'(done), 32'd1);
        chk("intr.rdata", rdata, 32'hAAAAAAAA);
        @(posedge clock); #1;
        chk("intr.no_queue_busy", 32'(busy), 32'd0);
        op(1'b1, 1'b0, 9'h007, 32'h0, "rd7");
        chk("rd7.rdata", rdata, 32'h07070707);

        // Clear mid-write aborts the access
        @(negedge clock);
        write = 1'b1; addr = 9'h020; wdata = 32'h11111111;
        @(posedge clock); #1;
        write = 1'b0;
        chk("abort.busy_pre", 32'(busy), 32'd1);
        @(negedge clock); clear = 1'b1;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.rdata", rdata, 32'h0);
        @(negedge clock); clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("abort.no_done", 32'(done), 32'd0);
        end
        op(1'b1, 1'b0, 9'h020, 32'h0, "rd20");
        chk("rd20.rdata", rdata, 32'h20202020);

`ifdef MEM_PARITY_EN
        op(1'b0, 1'b1, 9'h030, 32'h00000001, "wr30");
        @(negedge clock);
        dut.u_ram.r_mem[9'h030] = dut.u_ram.r_mem[9'h030] ^ 33'h2;
        op(1'b1, 1'b0, 9'h030, 32'h0, "rd30");
        chk("rd30.perr", 32'(parity_err), 32'd1);
        op(1'b1, 1'b0, 9'h005, 32'h0, "rd5c");
        chk("rd5c.perr", 32'(parity_err), 32'd0);
`else
        chk("noparity.perr", 32'(parity_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
